// File: rtl/hhc_pkg.sv
// Widths, decode result types and Hamming(15,11)/(7,4) helpers
// shared by the hybrid product-code codec.
package hhc_pkg;

    localparam int DATA_W   = 44;
    localparam int ROWS     = 4;
    localparam int ROW_DATA = 11;
    localparam int ROW_CODE = 15;
    localparam int COL_CODE = 7;
    localparam int CODE_W   = 105;

    typedef struct packed {
        logic [ROW_DATA-1:0] data;
        logic                fix;
    } row_dec_t;

    typedef struct packed {
        logic [ROWS-1:0] data;
        logic            fix;
    } col_dec_t;

    // 1-based positions of the data bits inside each code word
    localparam int ROW_POS [ROW_DATA] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    localparam int COL_POS [ROWS]     = '{3, 5, 6, 7};

    function automatic logic [3:0] syn15(input logic [ROW_CODE-1:0] w);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < ROW_CODE; k++)
            if (w[k]) s = s ^ 4'(k + 1);
        return s;
    endfunction

    function automatic logic [2:0] syn7(input logic [COL_CODE-1:0] w);
        logic [2:0] s;
        s = '0;
        for (int k = 0; k < COL_CODE; k++)
            if (w[k]) s = s ^ 3'(k + 1);
        return s;
    endfunction

    function automatic logic [ROW_CODE-1:0] ham15_encode(input logic [ROW_DATA-1:0] d);
        logic [ROW_CODE-1:0] w;
        logic [3:0]          s;
        w = '0;
        for (int i = 0; i < ROW_DATA; i++) w[ROW_POS[i] - 1] = d[i];
        s = syn15(w);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        w[7] = s[3];
        return w;
    endfunction

    function automatic row_dec_t ham15_decode(input logic [ROW_CODE-1:0] w_in);
        logic [ROW_CODE-1:0] w;
        logic [3:0]          s;
        row_dec_t            r;
        w = w_in;
        s = syn15(w);
        if (s != 4'd0) w[s - 4'd1] = ~w[s - 4'd1];
        for (int i = 0; i < ROW_DATA; i++) r.data[i] = w[ROW_POS[i] - 1];
        r.fix = (s != 4'd0);
        return r;
    endfunction

    function automatic logic [COL_CODE-1:0] ham7_encode(input logic [ROWS-1:0] d);
        logic [COL_CODE-1:0] w;
        logic [2:0]          s;
        w = '0;
        for (int i = 0; i < ROWS; i++) w[COL_POS[i] - 1] = d[i];
        s = syn7(w);
        w[0] = s[0];
        w[1] = s[1];
        w[3] = s[2];
        return w;
    endfunction

    function automatic col_dec_t ham7_decode(input logic [COL_CODE-1:0] w_in);
        logic [COL_CODE-1:0] w;
        logic [2:0]          s;
        col_dec_t            r;
        w = w_in;
        s = syn7(w);
        if (s != 3'd0) w[s - 3'd1] = ~w[s - 3'd1];
        for (int i = 0; i < ROWS; i++) r.data[i] = w[COL_POS[i] - 1];
        r.fix = (s != 3'd0);
        return r;
    endfunction

endpackage

// File: rtl/hhc_dec_core.sv
// Combinational decoder: column correction first, then row
// correction mops up what a column miscorrection leaves behind.
module hhc_dec_core
    import hhc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [DATA_W-1:0] data,
    output logic              col_fix,
    output logic              row_fix
);

    logic [ROWS-1:0][ROW_CODE-1:0] m;
    logic [DATA_W-1:0]             rows;
    col_dec_t                      cd;
    row_dec_t                      rd;

    always_comb begin
        m       = '0;
        rows    = '0;
        cd      = '0;
        rd      = '0;
        col_fix = 1'b0;
        row_fix = 1'b0;
        for (int j = 0; j < ROW_CODE; j++) begin
            cd      = ham7_decode(code[j*COL_CODE +: COL_CODE]);
            col_fix = col_fix | cd.fix;
            for (int r = 0; r < ROWS; r++) m[r][j] = cd.data[r];
        end
        for (int r = 0; r < ROWS; r++) begin
            rd      = ham15_decode(m[r]);
            row_fix = row_fix | rd.fix;
            rows[r*ROW_DATA +: ROW_DATA] = rd.data;
        end
    end

    hhc_interleave #(.INVERSE(1'b1)) u_dil (
        .a (rows),
        .y (data)
    );

endmodule

// File: rtl/hhc_enc_core.sv
// Combinational encoder: interleave, row Hamming(15,11),
// then column Hamming(7,4) across the 15 row-code bit positions.
module hhc_enc_core
    import hhc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] il,
    output logic [CODE_W-1:0] code
);

    logic [ROWS-1:0][ROW_CODE-1:0] m;

    hhc_interleave #(.INVERSE(1'b0)) u_il (
        .a (data),
        .y (il)
    );

    always_comb begin
        m    = '0;
        code = '0;
        for (int r = 0; r < ROWS; r++)
            m[r] = ham15_encode(il[r*ROW_DATA +: ROW_DATA]);
        for (int j = 0; j < ROW_CODE; j++)
            code[j*COL_CODE +: COL_CODE] =
                ham7_encode({m[3][j], m[2][j], m[1][j], m[0][j]});
    end

endmodule

// File: rtl/hhc_interleave.sv
// Bit transpose between linear data and the 4x11 row matrix;
// INVERSE selects row-matrix-to-linear.
module hhc_interleave
    import hhc_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        y = '0;
        for (int r = 0; r < ROWS; r++)
            for (int i = 0; i < ROW_DATA; i++)
                if (INVERSE) y[i*ROWS + r] = a[r*ROW_DATA + i];
                else         y[r*ROW_DATA + i] = a[i*ROWS + r];
    end

endmodule

// File: rtl/hybrid_hamming_codec.sv
// 44-bit product-code codec: independent one-cycle registered
// encode and decode paths around combinational cores.
module hybrid_hamming_codec
    import hhc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              enc_out_valid,
    output logic [DATA_W-1:0] interleaved_out,
    output logic [CODE_W-1:0] encoded_out,
    input  logic              dec_in_valid,
    input  logic [CODE_W-1:0] code_in,
    output logic              dec_out_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              col_corrected,
    output logic              row_corrected
);

    logic [DATA_W-1:0] il_c;
    logic [CODE_W-1:0] code_c;
    logic [DATA_W-1:0] data_c;
    logic              col_c;
    logic              row_c;

    hhc_enc_core u_enc (
        .data (data_in),
        .il   (il_c),
        .code (code_c)
    );

    hhc_dec_core u_dec (
        .code    (code_in),
        .data    (data_c),
        .col_fix (col_c),
        .row_fix (row_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_out_valid   <= 1'b0;
            interleaved_out <= '0;
            encoded_out     <= '0;
        end else begin
            enc_out_valid <= enc_in_valid;
            if (enc_in_valid) begin
                interleaved_out <= il_c;
                encoded_out     <= code_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_out_valid <= 1'b0;
            data_out      <= '0;
            col_corrected <= 1'b0;
            row_corrected <= 1'b0;
        end else begin
            dec_out_valid <= dec_in_valid;
            if (dec_in_valid) begin
                data_out      <= data_c;
                col_corrected <= col_c;
                row_corrected <= row_c;
            end
        end
    end

endmodule

// File: tb/tb_hybrid_hamming_codec.sv
// Randomized self-checking bench for hybrid_hamming_codec against
// a positional Hamming model and error-pattern based flag rules.
module tb_hybrid_hamming_codec;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enc_in_valid;
    logic [43:0]  data_in;
    logic         enc_out_valid;
    logic [43:0]  interleaved_out;
    logic [104:0] encoded_out;
    logic         dec_in_valid;
    logic [104:0] code_in;
    logic         dec_out_valid;
    logic [43:0]  data_out;
    logic         col_corrected;
    logic         row_corrected;

    int tests = 0;
    int fails = 0;

    logic [43:0] dec_orig;
    int          dec_errs;

    logic         m_enc_v;
    logic [43:0]  m_il;
    logic [104:0] m_code;
    logic         m_dec_v;
    logic [43:0]  m_data;
    logic         m_col;
    logic         m_row;

    hybrid_hamming_codec dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enc_in_valid    (enc_in_valid),
        .data_in         (data_in),
        .enc_out_valid   (enc_out_valid),
        .interleaved_out (interleaved_out),
        .encoded_out     (encoded_out),
        .dec_in_valid    (dec_in_valid),
        .code_in         (code_in),
        .dec_out_valid   (dec_out_valid),
        .data_out        (data_out),
        .col_corrected   (col_corrected),
        .row_corrected   (row_corrected)
    );

    always #5 clk = ~clk;

    function automatic logic [43:0] model_il(input logic [43:0] d);
        logic [43:0] il;
        il = '0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 11; i++)
                il[r*11 + i] = d[i*4 + r];
        return il;
    endfunction

    // Hamming word of length n: data fills non-power-of-two positions
    function automatic logic [15:0] ham_word(input int n, input logic [10:0] d);
        logic [15:0] w;
        int idx;
        bit par;
        w = '0;
        idx = 0;
        for (int pos = 1; pos <= n; pos++)
            if ((pos & (pos - 1)) != 0) begin
                w[pos-1] = d[idx];
                idx++;
            end
        for (int p = 1; p <= n; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= n; pos++)
                if (((pos & (pos - 1)) != 0) && ((pos & p) != 0))
                    par = par ^ w[pos-1];
            w[p-1] = par;
        end
        return w;
    endfunction

    function automatic logic [104:0] model_encode(input logic [43:0] d);
        logic [43:0]  il;
        logic [15:0]  rw [4];
        logic [15:0]  cw;
        logic [10:0]  cd;
        logic [104:0] code;
        il = model_il(d);
        code = '0;
        for (int r = 0; r < 4; r++) rw[r] = ham_word(15, il[r*11 +: 11]);
        for (int j = 0; j < 15; j++) begin
            cd = {7'b0, rw[3][j], rw[2][j], rw[1][j], rw[0][j]};
            cw = ham_word(7, cd);
            code[j*7 +: 7] = cw[6:0];
        end
        return code;
    endfunction

    task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what the outputs must show after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_enc_v <= 1'b0;
            m_il    <= '0;
            m_code  <= '0;
            m_dec_v <= 1'b0;
            m_data  <= '0;
            m_col   <= 1'b0;
            m_row   <= 1'b0;
        end else begin
            m_enc_v <= enc_in_valid;
            if (enc_in_valid) begin
                m_il   <= model_il(data_in);
                m_code <= model_encode(data_in);
            end
            m_dec_v <= dec_in_valid;
            if (dec_in_valid) begin
                m_data <= dec_orig;
                m_col  <= (dec_errs != 0);
                m_row  <= (dec_errs == 2);
            end
        end
    end

    always @(negedge clk) begin
        chk("enc_out_valid", 105'(enc_out_valid), 105'(m_enc_v));
        chk("interleaved_out", 105'(interleaved_out), 105'(m_il));
        chk("encoded_out", encoded_out, m_code);
        chk("dec_out_valid", 105'(dec_out_valid), 105'(m_dec_v));
        chk("data_out", 105'(data_out), 105'(m_data));
        chk("col_corrected", 105'(col_corrected), 105'(m_col));
        chk("row_corrected", 105'(row_corrected), 105'(m_row));
    end

    task automatic send(input bit ev, input logic [43:0] ed, input bit dv,
                        input logic [43:0] orig, input int errs, input logic [104:0] flip);
        @(negedge clk);
        enc_in_valid = ev;
        data_in      = ed;
        dec_in_valid = dv;
        dec_orig     = orig;
        dec_errs     = errs;
        code_in      = model_encode(orig) ^ flip;
    endtask

    function automatic logic [43:0] rnd44();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[43:0];
    endfunction

    initial begin
        logic [104:0] flip;
        logic [43:0]  d;

        rst_n        = 1'b0;
        enc_in_valid = 1'b0;
        data_in      = '0;
        dec_in_valid = 1'b0;
        code_in      = '0;
        dec_orig     = '0;
        dec_errs     = 0;

        chk("pin_enc_zero", model_encode(44'h0), 105'h0);
        chk("pin_enc_ones", model_encode({44{1'b1}}), {105{1'b1}});
        chk("pin_enc_one", model_encode(44'h1), 105'h1C387);
        chk("pin_il_two", 105'(model_il(44'h2)), 105'h800);

        repeat (2) @(negedge clk);
        chk("reset_enc_code", encoded_out, 105'h0);
        chk("reset_data_out", 105'(data_out), 105'h0);
        rst_n = 1'b1;

        send(1'b1, 44'h0, 1'b1, 44'h0, 0, 105'h0);
        @(posedge clk); #1;
        chk("lit_zero_code", encoded_out, 105'h0);
        chk("lit_zero_data", 105'(data_out), 105'h0);
        chk("lit_zero_flags", 105'({col_corrected, row_corrected}), 105'h0);
        chk("lit_zero_valids", 105'({enc_out_valid, dec_out_valid}), 105'h3);

        send(1'b1, {44{1'b1}}, 1'b1, {44{1'b1}}, 0, 105'h0);
        @(posedge clk); #1;
        chk("lit_ones_code", encoded_out, {105{1'b1}});
        chk("lit_ones_data", 105'(data_out), 105'(44'hFFFFFFFFFFF));

        send(1'b1, 44'h1, 1'b1, 44'h123456789AB, 1, 105'h1);
        @(posedge clk); #1;
        chk("lit_one_code", encoded_out, 105'h1C387);
        chk("lit_one_il", 105'(interleaved_out), 105'h1);
        chk("lit_bit0_data", 105'(data_out), 105'(44'h123456789AB));
        chk("lit_bit0_col", 105'(col_corrected), 105'h1);

        send(1'b1, 44'h2, 1'b1, 44'hAAAAAAAAAAA, 2, 105'h3 << 40);
        @(posedge clk); #1;
        chk("lit_two_il", 105'(interleaved_out), 105'h800);
        chk("lit_col5_data", 105'(data_out), 105'(44'hAAAAAAAAAAA));
        chk("lit_col5_row", 105'(row_corrected), 105'h1);

        send(1'b0, 44'h0, 1'b0, 44'h0, 0, 105'h0);
        @(posedge clk); #1;
        chk("lit_idle_valids", 105'({enc_out_valid, dec_out_valid}), 105'h0);
        chk("lit_idle_hold", 105'(data_out), 105'(44'hAAAAAAAAAAA));

        for (int p = 0; p < 105; p++) begin
            if ($urandom_range(0, 7) == 0)
                send(1'b0, rnd44(), 1'b0, rnd44(), 0, 105'h0);
            flip = '0;
            flip[p] = 1'b1;
            send(1'($urandom_range(0, 1)), rnd44(), 1'b1, rnd44(), 1, flip);
        end

        for (int c = 0; c < 15; c++)
            for (int a = 0; a < 6; a++)
                for (int b = a + 1; b < 7; b++) begin
                    if ($urandom_range(0, 7) == 0)
                        send(1'b0, rnd44(), 1'b0, rnd44(), 0, 105'h0);
                    flip = '0;
                    flip[c*7 + a] = 1'b1;
                    flip[c*7 + b] = 1'b1;
                    send(1'($urandom_range(0, 1)), rnd44(), 1'b1, rnd44(), 2, flip);
                end

        send(1'b1, 44'hFFFFFFFFFFF, 1'b1, 44'h0, 0, 105'h0);
        send(1'b1, rnd44(), 1'b1, rnd44(), 0, 105'h0);
        flip = '0;
        flip[50] = 1'b1;
        send(1'b1, rnd44(), 1'b1, rnd44(), 1, flip);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_enc_valid", 105'(enc_out_valid), 105'h0);
        chk("midrst_il", 105'(interleaved_out), 105'h0);
        chk("midrst_code", encoded_out, 105'h0);
        chk("midrst_dec_valid", 105'(dec_out_valid), 105'h0);
        chk("midrst_data", 105'(data_out), 105'h0);
        chk("midrst_flags", 105'({col_corrected, row_corrected}), 105'h0);
        @(negedge clk);
        rst_n = 1'b1;

        d = 44'h0F0F1234ABC;
        flip = '0;
        flip[99] = 1'b1;
        flip[102] = 1'b1;
        send(1'b0, 44'h0, 1'b1, d, 2, flip);
        @(posedge clk); #1;
        chk("post_rst_data", 105'(data_out), 105'(d));
        chk("post_rst_valid", 105'(dec_out_valid), 105'h1);

        repeat (3) send(1'b0, 44'h0, 1'b0, 44'h0, 0, 105'h0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
